// File: rtl/debouncer_pkg.sv
// Shared types and constants for the button debouncer.
package debouncer_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam int STABLE_CYCLES_DEF = 16;

endpackage

// File: rtl/debouncer_sync_2ff.sv
// Two-flop synchronizer for the raw button level; async active-high reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/debouncer.sv
// Button debouncer: input stage then a 4-state qualification FSM.
// DEBOUNCER_SYNC_EN selects a 2-flop synchronizer instead of a single input flop.
//   state        | meaning
//   RELEASED     | output 0, input low
//   PRESS_WAIT   | input high, counting toward press
//   PRESSED      | output 1, input high
//   RELEASE_WAIT | input low, counting toward release
module debouncer
  import debouncer_pkg::*;
#(
  parameter  int STABLE_CYCLES = STABLE_CYCLES_DEF,
  localparam int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic down,
  output logic debounceOut
);

  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic w_s;

`ifdef DEBOUNCER_SYNC_EN
  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (down),
    .q   (w_s)
  );
`else
  logic r_down_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_down_q <= 1'b0;
    else     r_down_q <= down;
  end

  assign w_s = r_down_q;
`endif

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             r_out;
  logic             w_out_nxt;

  // Saturating increment so the counter can never wrap.
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RELEASED;
      r_cnt   <= '0;
      r_out   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_out   <= w_out_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_out_nxt   = r_out;
    case (r_state)
      RELEASED: begin
        if (w_s) begin
          w_state_nxt = PRESS_WAIT;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!w_s) begin
          w_state_nxt = RELEASED;
          w_cnt_nxt   = '0;
          w_out_nxt   = 1'b0;
        end else if (r_cnt >= CNT_TERM) begin
          w_state_nxt = PRESSED;
          w_cnt_nxt   = '0;
          w_out_nxt   = 1'b1;
        end else begin
          w_cnt_nxt   = w_cnt_inc;
        end
      end
      PRESSED: begin
        if (!w_s) begin
          w_state_nxt = RELEASE_WAIT;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (w_s) begin
          w_state_nxt = PRESSED;
          w_cnt_nxt   = '0;
          w_out_nxt   = 1'b1;
        end else if (r_cnt >= CNT_TERM) begin
          w_state_nxt = RELEASED;
          w_cnt_nxt   = '0;
          w_out_nxt   = 1'b0;
        end else begin
          w_cnt_nxt   = w_cnt_inc;
        end
      end
      default: begin
        w_state_nxt = RELEASED;
        w_cnt_nxt   = '0;
        w_out_nxt   = 1'b0;
      end
    endcase
  end

  assign debounceOut = r_out;

endmodule

// File: tb/tb_debouncer.sv
// Scoreboard bench for debouncer (STABLE_CYCLES=16); follows DEBOUNCER_SYNC_EN if defined.
module tb_debouncer;
  import debouncer_pkg::*;

  localparam int STB = 16;
`ifdef DEBOUNCER_SYNC_EN
  localparam int DELAY = 2;
`else
  localparam int DELAY = 1;
`endif

  logic clk;
  logic rst;
  logic down;
  logic debounceOut;

  int n_checks = 0;
  int n_errors = 0;

  logic           exp_q[$];
  logic           pipe[2];
  logic [STB-1:0] hist;
  logic           mdl_out;

  debouncer #(.STABLE_CYCLES(STB)) dut (
    .clk         (clk),
    .rst         (rst),
    .down        (down),
    .debounceOut (debounceOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    pipe[0] = 1'b0;
    pipe[1] = 1'b0;
    hist    = '0;
    mdl_out = 1'b0;
  endtask

  // Output flips once the last STB levels seen by the FSM all oppose the current output.
  task automatic model_edge(input logic d);
    logic seen;
    seen    = (DELAY == 2) ? pipe[1] : pipe[0];
    pipe[1] = pipe[0];
    pipe[0] = d;
    hist    = {hist[STB-2:0], seen};
    if (hist == {STB{~mdl_out}}) mdl_out = ~mdl_out;
  endtask

  // Called at a negedge; drives one cycle and ends at the next negedge.
  task automatic step(input logic d, input string tag);
    down = d;
    model_edge(d);
    exp_q.push_back(mdl_out);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) check({tag, "_underflow"}, 1, 0);
    else check(tag, {31'd0, debounceOut}, {31'd0, exp_q.pop_front()});
    @(negedge clk);
  endtask

  task automatic measure(input logic d, input logic target, input int maxn, input string tag);
    int edge_n;
    edge_n = -1;
    for (int i = 1; i <= maxn; i++) begin
      step(d, tag);
      if (debounceOut == target && edge_n < 0) edge_n = i;
    end
    check({tag, "_edge"}, edge_n, DELAY + STB);
  endtask

  task automatic do_reset(input logic d, input string tag);
    down = d;
    #2;
    rst = 1'b1;
    #1;
    check({tag, "_out"}, {31'd0, debounceOut}, 0);
    check({tag, "_cnt"}, dut.r_cnt, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_out"}, {31'd0, debounceOut}, 0);
      check({tag, "_state"}, dut.r_state, RELEASED);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic lvl;
    rst  = 1'b1;
    down = 1'b1;
    model_reset();
    @(negedge clk);

    do_reset(1'b1, "rst_hold");
    measure(1'b1, 1'b1, 30, "rise_after_rst");
    for (int i = 0; i < 10; i++) step(1'b1, "stay_high");
    measure(1'b0, 1'b0, 30, "clean_release");

    for (int i = 0; i < 10; i++) step(1'b1, "short_pulse_hi");
    for (int i = 0; i < 30; i++) step(1'b0, "short_pulse_lo");
    check("short_pulse_state", dut.r_state, RELEASED);

    for (int i = 0; i < 25; i++) step(1'b1, "get_pressed");
    check("pressed_state", dut.r_state, PRESSED);
    for (int i = 0; i < 5; i++) step(1'b0, "bounce_lo");
    for (int i = 0; i < 3; i++) step(1'b1, "bounce_hi");
    measure(1'b0, 1'b0, 25, "bounce_release");

    for (int i = 0; i < DELAY + 9; i++) step(1'b1, "qual_partial");
    check("qual_cnt", dut.r_cnt, 9);
    check("qual_state", dut.r_state, PRESS_WAIT);
    do_reset(1'b1, "rst_mid");
    measure(1'b1, 1'b1, 30, "rise_after_mid_rst");

    lvl = 1'b0;
    for (int seg = 0; seg < 40; seg++) begin
      int len;
      len = $urandom_range(1, 25);
      for (int i = 0; i < len; i++) step(lvl, "random");
      lvl = ~lvl;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "bench time limit");
  end

endmodule
